// File: rtl/bram_ctrl_pkg.sv
// Shared definitions for the BRAM port controllers: FSM state encoding,
// byte-lane count derivation and the legal BRAM read-latency range.
// No ports (package).
package bram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD    = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned MIN_RD_LATENCY = 1;
    localparam int unsigned MAX_RD_LATENCY = 3;

    // Number of byte lanes for a data width that is a multiple of 8.
    function automatic int unsigned num_byte(input int unsigned dat_width);
        return dat_width / 8;
    endfunction

    // True when the BRAM read latency is one the valid pipeline supports.
    function automatic bit rd_latency_ok(input int unsigned lat);
        return (lat >= MIN_RD_LATENCY) && (lat <= MAX_RD_LATENCY);
    endfunction

endpackage

// File: rtl/rd_valid_pipe.sv
// Valid shift register that tracks outstanding BRAM reads.
// Ports:
//   clk     in   clock
//   clr_n   in   synchronous active-low clear
//   push    in   a read is issued this cycle
//   vld     out  read data is on the BRAM output this cycle
//   pending out  issued reads still travelling toward the output stage
module rd_valid_pipe #(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic clr_n,
    input  logic push,
    output logic vld,
    output logic pending
);

    logic [DEPTH-1:0] stages;

    if (DEPTH == 1) begin : g_one
        always_ff @(posedge clk) begin
            if (!clr_n) begin
                stages <= '0;
            end else begin
                stages <= push;
            end
        end
        assign pending = 1'b0;
    end else begin : g_many
        always_ff @(posedge clk) begin
            if (!clr_n) begin
                stages <= '0;
            end else begin
                stages <= {stages[DEPTH-2:0], push};
            end
        end
        // Beats not yet in the output stage.
        assign pending = |stages[DEPTH-2:0];
    end

    assign vld = stages[DEPTH-1];

endmodule

// File: rtl/bram_burst_ctrl.sv
// BRAM port controller: single-beat byte-enable writes and burst reads with
// a valid/ready request handshake, configurable read latency and a hold
// register that keeps the last read beat on odat.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req_val/req_rdy               request handshake
//   req_wr, req_addr, req_len     request kind, word address, beats-1
//   req_be, idat                  write byte enables and data
//   odat, oval, busy              read data, read beat valid, burst active
//   mem_addr, mem_idat, mem_odat  BRAM address, write data, read data
//   mem_wren, mem_enb, mem_rst    BRAM byte write enables, enable, out reset
module bram_burst_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int unsigned DAT_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned ADDR_MODE  = 0,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_val,
    output logic                            req_rdy,
    input  logic                            req_wr,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [LEN_WIDTH-1:0]            req_len,
    input  logic [num_byte(DAT_WIDTH)-1:0]  req_be,
    input  logic [DAT_WIDTH-1:0]            idat,
    output logic [DAT_WIDTH-1:0]            odat,
    output logic                            oval,
    output logic                            busy,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DAT_WIDTH-1:0]            mem_idat,
    input  logic [DAT_WIDTH-1:0]            mem_odat,
    output logic [num_byte(DAT_WIDTH)-1:0]  mem_wren,
    output logic                            mem_enb,
    output logic                            mem_rst
);

    localparam int unsigned NUM_BYTE = num_byte(DAT_WIDTH);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("bram_burst_ctrl: RD_LATENCY must be within 1..3");
    end
    if ((DAT_WIDTH % 8) != 0) begin : g_bad_width
        $error("bram_burst_ctrl: DAT_WIDTH must be a multiple of 8");
    end

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   beat_addr;
    logic [LEN_WIDTH-1:0]    beat_cnt;
    logic [DAT_WIDTH-1:0]    hold;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    accept;
    logic                    wr_fire;
    logic                    rd_fire;
    logic                    rd_push;
    logic                    pending;

    // req_rdy is only ever high in IDLE, so it qualifies acceptance alone.
    assign accept  = req_val && req_rdy;
    assign wr_fire = accept && req_wr;
    assign rd_fire = accept && !req_wr;
    assign rd_push = (state == RD);

    rd_valid_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_vpipe (
        .clk     (clk),
        .clr_n   (rst),
        .push    (rd_push),
        .vld     (oval),
        .pending (pending)
    );

    // Request FSM with registered handshake/status outputs and beat counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            beat_addr <= '0;
            beat_cnt  <= '0;
            req_rdy   <= 1'b0;
            busy      <= 1'b0;
            hold      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_fire) begin
                        beat_addr <= req_addr;
                        beat_cnt  <= req_len;
                        state     <= RD;
                        req_rdy   <= 1'b0;
                        busy      <= 1'b1;
                    end else begin
                        // Also raises req_rdy on the first cycle after reset.
                        req_rdy <= 1'b1;
                    end
                end
                RD: begin
                    beat_addr <= beat_addr + ADDR_WIDTH'(1);
                    beat_cnt  <= beat_cnt - LEN_WIDTH'(1);
                    if (beat_cnt == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last beat is in the output stage this cycle.
                    if (!pending) begin
                        state   <= IDLE;
                        req_rdy <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_rdy <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase

            if (oval) begin
                hold <= mem_odat;
            end
        end
    end

    // Memory port: writes pass straight through, reads come from the beat counter.
    always_comb begin
        word_addr = beat_addr;
        mem_enb   = 1'b0;
        mem_wren  = '0;
        if (wr_fire) begin
            word_addr = req_addr;
            mem_enb   = 1'b1;
            mem_wren  = req_be;
        end else if (state == RD) begin
            mem_enb = 1'b1;
        end
    end

    assign mem_addr = word_addr << ADDR_MODE;
    assign mem_idat = idat;
    assign mem_rst  = 1'b0;
    assign odat     = oval ? mem_odat : hold;

    logic unused_ok;
    assign unused_ok = ^{NUM_BYTE[0]};

endmodule

// File: doc/bram_burst_ctrl.md
# bram_burst_ctrl

Next-generation BRAM port controller between accelerator datapaths (weight/feature loaders, result writers) and a true-dual-port BRAM port. It adds burst reads with up to 2^LEN_WIDTH beats, byte-enable writes, a valid/ready request handshake, configurable BRAM read latency and an output hold register. One instance drives one BRAM port.

## Interface
Parameters:
- DAT_WIDTH, 32, data width in bits; a multiple of 8. NUM_BYTE = DAT_WIDTH/8.
- ADDR_WIDTH, 32, address width in bits, for both user and memory addresses.
- ADDR_MODE, 0, left shift from word address to memory address. Use 2 for a byte-addressed 32-bit BRAM.
- RD_LATENCY, 1, BRAM read latency in cycles, legal range 1..3.
- LEN_WIDTH, 8, width of the burst length field.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- req_val  in  1  request valid.
- req_rdy  out  1  controller accepts a request. A request is accepted on a cycle where req_val=1 and req_rdy=1.
- req_wr  in  1  1 = single-beat write, 0 = burst read.
- req_addr  in  ADDR_WIDTH  word address of the write, or of the first read beat.
- req_len  in  LEN_WIDTH  number of read beats minus 1. Ignored for writes.
- req_be  in  NUM_BYTE  byte enables for a write.
- idat  in  DAT_WIDTH  write data.
- odat  out  DAT_WIDTH  read data.
- oval  out  1  odat carries a new read beat.
- busy  out  1  a read burst is in progress.
- mem_addr  out  ADDR_WIDTH  memory address, equal to the word address << ADDR_MODE, truncated to ADDR_WIDTH.
- mem_idat  out  DAT_WIDTH  memory write data.
- mem_odat  in  DAT_WIDTH  memory read data.
- mem_wren  out  NUM_BYTE  memory byte write enables.
- mem_enb  out  1  memory port enable.
- mem_rst  out  1  memory output reset; tied to 0.

## Operation
- FSM states:
  - IDLE: req_rdy=1.
    - An accepted write goes combinationally to memory in the same cycle: mem_addr from req_addr, mem_idat=idat, mem_wren=req_be, mem_enb=1. The FSM stays in IDLE, so writes sustain one per cycle.
    - An accepted read latches the base address into the beat address counter and req_len into the beat counter, then goes to RD.
  - RD: req_rdy=0.
    - Each cycle: issue mem_addr from the beat address, mem_enb=1, mem_wren=0. Push a 1 into the valid pipeline, increment the beat address, decrement the beat counter.
    - After the beat with counter value 0, go to DRAIN.
  - DRAIN: req_rdy=0, no memory access. When the last beat leaves the valid pipeline, go to IDLE.
- Valid pipeline: an RD_LATENCY-stage shift register. Its output drives oval, and odat=mem_odat whenever oval=1.
- Output hold: when oval=1, mem_odat is registered. When oval=0, odat shows that register, i.e. the last beat read.
- The beat address wraps modulo 2^ADDR_WIDTH. Base 2^ADDR_WIDTH−1 is followed by 0.
- The shift of the word address by ADDR_MODE drops the upper bits.
- req_val with req_rdy=0 is ignored. Nothing is queued; the requester must hold req_val.
- busy=1 in RD and DRAIN.
- mem_enb=0 and mem_wren=0 when no access is issued.
- Reset (rst=0, evaluated on the clock edge):
  - FSM goes to IDLE, counters cleared, valid pipeline cleared, hold register cleared.
  - Outputs: oval=0, odat=0, busy=0, mem_wren=0, mem_enb=0.
  - req_rdy=0 while rst=0.
  - Reset in the middle of a burst aborts it; no further beats appear on oval.

## Timing
- Read accepted at cycle T:
  - Beat i is issued at T+1+i.
  - Beat i appears with oval=1 at T+1+i+RD_LATENCY.
  - The last beat appears at T+1+req_len+RD_LATENCY.
  - req_rdy=1 again at T+2+req_len+RD_LATENCY.
- Beats are back-to-back with no bubbles. There is no backpressure on the output.
- Write accepted at T: the memory write occurs on the clk edge ending cycle T. Write throughput is 1 per cycle.
- A write to address A accepted at T followed by a read of A accepted at T+1 returns the new data. The memory is assumed to be write-first or to have separate cycles.

## Structure
- Package bram_ctrl_pkg holds:
  - the state encoding IDLE/RD/DRAIN;
  - the NUM_BYTE derivation;
  - a RD_LATENCY range check.
- Sub-module rd_valid_pipe: parametrised-depth valid shift register with synchronous active-low clear. It is reused by the other memory controllers.

## Test plan
- Write: addr 0x10, be 4'b0011, idat 0xAABBCCDD, over prior content 0x11223344 -> mem_wren=4'b0011 in the accept cycle; a read of 0x10 returns 0x1122CCDD.
- Read burst: RD_LATENCY=2, addr 0x20, len 3, memory holds k at address k, accept at T -> oval=1 at T+3..T+6 with odat 0x20..0x23; req_rdy=1 at T+7; odat stays 0x23 afterwards.
- Wrap: ADDR_WIDTH=4, addr 0xE, len 3 -> mem_addr sequence 0xE, 0xF, 0x0, 0x1.
- ADDR_MODE=2, read word 5 -> mem_addr=0x14.
- Busy: req_val=1 held high during a burst -> no accept until req_rdy=1; exactly one extra accept after that.
- Reset mid-burst: rst=0 during the second beat of a len-7 burst -> oval=0, odat=0, busy=0 on the next cycle; no further beats; req_rdy=1 one cycle after rst returns to 1.
